// File: rtl/xyz_response_compactor.sv
// xyz_response_compactor
//   Samples the x/y/z outputs of the 5-input/3-output logic block, one vector
//   per in_valid/in_ready handshake, and compacts a run of NUM_VEC vectors into
//   a MISR signature plus per-output ones-counts. The finished result is
//   offered on a sig_valid/sig_ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        begin a run (IDLE only) / cancel the current run
//   in_valid, x, y, z   response vector from the logic block
//   in_ready            vector is accepted this cycle (CAPTURE)
//   busy                a run or result hand-off is in progress
//   sig_valid, sig_ready  result handshake
//   signature           MISR value
//   vec_count           vectors accepted in the current or last run
//   ones_x/y/z          accepted vectors with that output bit set
//
// All outputs come straight from registers (state decode or result regs),
// so there is no combinational path from any input to any output.

module xyz_response_compactor #(
  parameter int              SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000,
  parameter int              NUM_VEC = 32,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             in_ready,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] ones_x,
  output logic [CNT_W-1:0] ones_y,
  output logic [CNT_W-1:0] ones_z
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [SIG_W-1:0] sig_r, sig_s;
  logic [CNT_W-1:0] vec_r, vec_s;
  logic [CNT_W-1:0] ox_r, ox_s;
  logic [CNT_W-1:0] oy_r, oy_s;
  logic [CNT_W-1:0] oz_r, oz_s;
  logic [CNT_W-1:0] vec_inc_s;

  // One MISR shift: shift left, fold the polynomial in when the MSB falls
  // out, and inject the response with x in bit 0, y in bit 1, z in bit 2.
  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0] cur,
    input logic             bx,
    input logic             by,
    input logic             bz
  );
    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] fb_term;
    logic [SIG_W-1:0] data_term;
    shifted   = {cur[SIG_W-2:0], 1'b0};
    fb_term   = cur[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    data_term = {{(SIG_W-3){1'b0}}, bz, by, bx};
    return shifted ^ fb_term ^ data_term;
  endfunction

  // Add one bit to a counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] cnt,
    input logic             inc
  );
    logic [CNT_W-1:0] res;
    if (inc && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  // Next state and next result values; abort dominates start, accept and sig_ready.
  always_comb begin
    state_s   = state_r;
    sig_s     = sig_r;
    vec_s     = vec_r;
    ox_s      = ox_r;
    oy_s      = oy_r;
    oz_s      = oz_r;
    vec_inc_s = sat_inc(vec_r, 1'b1);
    case (state_r)
      S_IDLE: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (start) begin
          state_s = S_CAPTURE;
          sig_s   = SEED;
          vec_s   = {CNT_W{1'b0}};
          ox_s    = {CNT_W{1'b0}};
          oy_s    = {CNT_W{1'b0}};
          oz_s    = {CNT_W{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (in_valid) begin
          sig_s = misr_step(sig_r, x, y, z);
          vec_s = vec_inc_s;
          ox_s  = sat_inc(ox_r, x);
          oy_s  = sat_inc(oy_r, y);
          oz_s  = sat_inc(oz_r, z);
          if (vec_inc_s == CNT_W'(NUM_VEC)) begin
            state_s = S_HOLD;
          end else begin
            state_s = S_CAPTURE;
          end
        end else begin
          state_s = S_CAPTURE;
        end
      end
      S_HOLD: begin
        if (abort || sig_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      sig_r   <= SEED;
      vec_r   <= {CNT_W{1'b0}};
      ox_r    <= {CNT_W{1'b0}};
      oy_r    <= {CNT_W{1'b0}};
      oz_r    <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      sig_r   <= sig_s;
      vec_r   <= vec_s;
      ox_r    <= ox_s;
      oy_r    <= oy_s;
      oz_r    <= oz_s;
    end
  end

  assign in_ready  = (state_r == S_CAPTURE);
  assign busy      = (state_r != S_IDLE);
  assign sig_valid = (state_r == S_HOLD);
  assign signature = sig_r;
  assign vec_count = vec_r;
  assign ones_x    = ox_r;
  assign ones_y    = oy_r;
  assign ones_z    = oz_r;

endmodule

// File: tb/tb_xyz_response_compactor.sv
// Bench for xyz_response_compactor. Five instances with different SEED/NUM_VEC
// share the data inputs and have private start lines. Expected results are
// pushed to a scoreboard queue as vectors are driven; a negedge monitor pops
// and compares whenever an instance raises sig_valid.
module tb_xyz_response_compactor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] start_v;
  logic       abort, in_valid, x, y, z, sig_ready;
  logic [4:0] in_ready_v, busy_v, sig_valid_v;
  logic [15:0] sig_v [5];
  logic [7:0]  vc_v [5];
  logic [7:0]  ox_v [5];
  logic [7:0]  oy_v [5];
  logic [7:0]  oz_v [5];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] sig;
    logic [7:0]  vc;
    logic [7:0]  ox;
    logic [7:0]  oy;
    logic [7:0]  oz;
  } exp_t;

  exp_t exp_q[$];
  logic [4:0] sv_prev;

  logic [15:0] m_sig;
  logic [7:0]  m_vc, m_ox, m_oy, m_oz;

  always #5 clk = ~clk;

  // 0: SEED 0 / 1 vec, 1: SEED 0 / 2 vec, 2: SEED 8000 / 1 vec, 3: 32 vec, 4: 255 vec
  for (genvar g = 0; g < 5; g++) begin : g_dut
    xyz_response_compactor #(
      .SIG_W  (16),
      .POLY   (16'h1021),
      .SEED   ((g == 2) ? 16'h8000 : 16'h0000),
      .NUM_VEC((g == 0 || g == 2) ? 1 : (g == 1) ? 2 : (g == 3) ? 32 : 255),
      .CNT_W  (8)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[g]),
      .abort    (abort),
      .in_valid (in_valid),
      .x        (x),
      .y        (y),
      .z        (z),
      .in_ready (in_ready_v[g]),
      .busy     (busy_v[g]),
      .sig_valid(sig_valid_v[g]),
      .sig_ready(sig_ready),
      .signature(sig_v[g]),
      .vec_count(vc_v[g]),
      .ones_x   (ox_v[g]),
      .ones_y   (oy_v[g]),
      .ones_z   (oz_v[g])
    );
  end

  function automatic logic [15:0] misr(input logic [15:0] s, input logic a, b, c);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'd0, c, b, a};
  endfunction

  function automatic logic [7:0] sat8(input logic [7:0] v, input logic inc);
    return (inc && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  // Scoreboard consumer: compare on each rising sig_valid.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (rst_n && sig_valid_v[i] && !sv_prev[i]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected dut=%0d sig_valid=1 with no expected result", i);
        end else begin
          e = exp_q.pop_front();
          if (e.id != 3'(i) || sig_v[i] !== e.sig || vc_v[i] !== e.vc ||
              ox_v[i] !== e.ox || oy_v[i] !== e.oy || oz_v[i] !== e.oz) begin
            bad++;
            $display("FAIL sb_result dut=%0d got sig=%h vc=%0d x=%0d y=%0d z=%0d exp dut=%0d sig=%h vc=%0d x=%0d y=%0d z=%0d",
                     i, sig_v[i], vc_v[i], ox_v[i], oy_v[i], oz_v[i],
                     e.id, e.sig, e.vc, e.ox, e.oy, e.oz);
          end
        end
      end
    end
    sv_prev <= sig_valid_v;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int k);
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
    m_sig = (k == 2) ? 16'h8000 : 16'h0000;
    m_vc = 8'd0; m_ox = 8'd0; m_oy = 8'd0; m_oz = 8'd0;
  endtask

  task automatic model_accept(input logic a, b, c);
    m_sig = misr(m_sig, a, b, c);
    m_vc  = sat8(m_vc, 1'b1);
    m_ox  = sat8(m_ox, a);
    m_oy  = sat8(m_oy, b);
    m_oz  = sat8(m_oz, c);
  endtask

  task automatic feed(input int k, input logic a, b, c);
    in_valid = 1'b1; x = a; y = b; z = c;
    if (in_ready_v[k]) model_accept(a, b, c);
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_expect(input int k);
    exp_q.push_back('{id: 3'(k), sig: m_sig, vc: m_vc, ox: m_ox, oy: m_oy, oz: m_oz});
  endtask

  task automatic handshake();
    sig_ready = 1'b1;
    step();
    sig_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (sig_v[k] !== ((k == 2) ? 16'h8000 : 16'h0000) || vc_v[k] !== 8'd0 ||
          ox_v[k] !== 8'd0 || oy_v[k] !== 8'd0 || oz_v[k] !== 8'd0 ||
          busy_v[k] !== 1'b0 || in_ready_v[k] !== 1'b0 || sig_valid_v[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset dut=%0d sig=%h vc=%0d busy=%b rdy=%b sv=%b want seed/zeros",
                 k, sig_v[k], vc_v[k], busy_v[k], in_ready_v[k], sig_valid_v[k]);
      end
    end
  endtask

  task automatic test_single();
    start_run(0);
    total++;
    if (busy_v[0] !== 1'b1 || in_ready_v[0] !== 1'b1) begin
      bad++; $display("FAIL start_capture busy=%b in_ready=%b want 1 1", busy_v[0], in_ready_v[0]);
    end
    feed(0, 1'b1, 1'b0, 1'b1);
    push_expect(0);
    total++;
    if (sig_v[0] !== 16'h0005 || vc_v[0] !== 8'd1 || ox_v[0] !== 8'd1 || oy_v[0] !== 8'd0 ||
        oz_v[0] !== 8'd1 || sig_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
      bad++;
      $display("FAIL single sig=%h vc=%0d x=%0d y=%0d z=%0d sv=%b rdy=%b want 0005 1 1 0 1 1 0",
               sig_v[0], vc_v[0], ox_v[0], oy_v[0], oz_v[0], sig_valid_v[0], in_ready_v[0]);
    end
    handshake();
    total++;
    if (busy_v[0] !== 1'b0 || sig_valid_v[0] !== 1'b0 || sig_v[0] !== 16'h0005) begin
      bad++;
      $display("FAIL single_release busy=%b sv=%b sig=%h want 0 0 0005", busy_v[0], sig_valid_v[0], sig_v[0]);
    end
  endtask

  task automatic test_two();
    start_run(1);
    feed(1, 1'b1, 1'b0, 1'b1);
    total++;
    if (sig_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
      bad++; $display("FAIL two_mid sv=%b rdy=%b want 0 1", sig_valid_v[1], in_ready_v[1]);
    end
    feed(1, 1'b1, 1'b1, 1'b1);
    push_expect(1);
    total++;
    if (sig_v[1] !== 16'h000D || vc_v[1] !== 8'd2 || ox_v[1] !== 8'd2 || oy_v[1] !== 8'd1 || oz_v[1] !== 8'd2) begin
      bad++;
      $display("FAIL two sig=%h vc=%0d x=%0d y=%0d z=%0d want 000D 2 2 1 2",
               sig_v[1], vc_v[1], ox_v[1], oy_v[1], oz_v[1]);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [15:0] first_sig;
    first_sig = m_sig;
    start_run(1);
    total++;
    if (busy_v[1] !== 1'b1 || sig_v[1] !== 16'h0000 || vc_v[1] !== 8'd0) begin
      bad++; $display("FAIL b2b_start busy=%b sig=%h vc=%0d want 1 0000 0", busy_v[1], sig_v[1], vc_v[1]);
    end
    feed(1, 1'b0, 1'b1, 1'b1);
    feed(1, 1'b1, 1'b1, 1'b0);
    push_expect(1);
    total++;
    if (sig_valid_v[1] !== 1'b1 || sig_v[1] !== m_sig || m_sig === first_sig) begin
      bad++; $display("FAIL b2b sv=%b sig=%h want 1 %h", sig_valid_v[1], sig_v[1], m_sig);
    end
    handshake();
  endtask

  task automatic test_feedback();
    start_run(2);
    feed(2, 1'b0, 1'b0, 1'b0);
    push_expect(2);
    total++;
    if (sig_v[2] !== 16'h1021 || vc_v[2] !== 8'd1 || ox_v[2] !== 8'd0) begin
      bad++; $display("FAIL feedback sig=%h vc=%0d want 1021 1", sig_v[2], vc_v[2]);
    end
    handshake();
  endtask

  task automatic test_hold();
    start_run(0);
    feed(0, 1'b1, 1'b1, 1'b0);
    push_expect(0);
    in_valid = 1'b1; x = 1'b1; y = 1'b1; z = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (sig_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || sig_v[0] !== 16'h0003 || vc_v[0] !== 8'd1) begin
        bad++;
        $display("FAIL hold cyc=%0d sv=%b rdy=%b sig=%h vc=%0d want 1 0 0003 1",
                 i, sig_valid_v[0], in_ready_v[0], sig_v[0], vc_v[0]);
      end
    end
    handshake();
    in_valid = 1'b0;
    total++;
    if (busy_v[0] !== 1'b0 || sig_valid_v[0] !== 1'b0 || sig_v[0] !== 16'h0003) begin
      bad++; $display("FAIL hold_release busy=%b sv=%b sig=%h want 0 0 0003", busy_v[0], sig_valid_v[0], sig_v[0]);
    end
  endtask

  task automatic test_abort();
    start_run(3);
    for (int i = 0; i < 3; i++) begin
      feed(3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    in_valid = 1'b1; x = 1'b1; y = 1'b1; z = 1'b1; abort = 1'b1;
    step();
    in_valid = 1'b0; abort = 1'b0;
    total++;
    if (busy_v[3] !== 1'b0 || in_ready_v[3] !== 1'b0 || sig_valid_v[3] !== 1'b0 || vc_v[3] !== 8'd3 ||
        sig_v[3] !== m_sig || ox_v[3] !== m_ox || oz_v[3] !== 8'd3) begin
      bad++;
      $display("FAIL abort busy=%b sv=%b vc=%0d sig=%h x=%0d z=%0d want 0 0 3 %h %0d 3",
               busy_v[3], sig_valid_v[3], vc_v[3], sig_v[3], ox_v[3], oz_v[3], m_sig, m_ox);
    end
    // start and abort together in IDLE: stays idle, results untouched
    start_v[3] = 1'b1; abort = 1'b1;
    step();
    start_v[3] = 1'b0; abort = 1'b0;
    total++;
    if (busy_v[3] !== 1'b0 || vc_v[3] !== 8'd3 || sig_v[3] !== m_sig) begin
      bad++; $display("FAIL start_abort busy=%b vc=%0d sig=%h want 0 3 %h", busy_v[3], vc_v[3], sig_v[3], m_sig);
    end
    // reset in the middle of a run
    start_run(3);
    feed(3, 1'b1, 1'b1, 1'b1);
    feed(3, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy_v[3] !== 1'b0 || in_ready_v[3] !== 1'b0 || sig_valid_v[3] !== 1'b0 || sig_v[3] !== 16'h0000 ||
        vc_v[3] !== 8'd0 || ox_v[3] !== 8'd0 || oy_v[3] !== 8'd0 || oz_v[3] !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid busy=%b rdy=%b sv=%b sig=%h vc=%0d x=%0d want all zero",
               busy_v[3], in_ready_v[3], sig_valid_v[3], sig_v[3], vc_v[3], ox_v[3]);
    end
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    int accepts;
    int cyc;
    accepts = 0;
    cyc = 0;
    start_run(4);
    while (accepts < 255 && cyc < 3000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      x = 1'b1; y = 1'b1; z = 1'b1;
      if (in_valid && in_ready_v[4]) begin
        accepts++;
        model_accept(1'b1, 1'b1, 1'b1);
        if (accepts == 255) push_expect(4);
      end
      step();
      cyc++;
    end
    total++;
    if (accepts != 255) begin
      bad++; $display("FAIL sat_accepts got=%0d want 255 within budget", accepts);
    end
    // keep offering vectors: none may be taken in HOLD
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    total++;
    if (vc_v[4] !== 8'd255 || ox_v[4] !== 8'd255 || oy_v[4] !== 8'd255 || oz_v[4] !== 8'd255 ||
        sig_v[4] !== m_sig || sig_valid_v[4] !== 1'b1) begin
      bad++;
      $display("FAIL saturation vc=%0d x=%0d y=%0d z=%0d sig=%h sv=%b want 255 255 255 255 %h 1",
               vc_v[4], ox_v[4], oy_v[4], oz_v[4], sig_v[4], sig_valid_v[4], m_sig);
    end
    handshake();
  endtask

  initial begin
    rst_n = 1'b0; start_v = 5'd0; abort = 1'b0; in_valid = 1'b0;
    x = 1'b0; y = 1'b0; z = 1'b0; sig_ready = 1'b0;
    #22;
    rst_n = 1'b1;
    step();
    test_reset();
    test_single();
    test_two();
    test_back_to_back();
    test_feedback();
    test_hold();
    test_abort();
    test_saturation();
    step();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
